// File: rtl/mod_matrix_pkg.sv
// Shared widths, sample/level/accumulator/output types and the gain-shift-saturate
// helper used by the modulation-matrix MAC.
package mod_matrix_pkg;

  localparam int VOICES_D    = 8;
  localparam int V_OSC_D     = 4;
  localparam int V_WIDTH_D   = 3;
  localparam int O_WIDTH_D   = 2;
  localparam int IN_W_D      = 17;
  localparam int LVL_W_D     = 8;
  localparam int ACC_W_D     = 40;
  localparam int OUT_W_D     = 11;
  localparam int OUT_SHIFT_D = 26;

  typedef logic signed [IN_W_D-1:0]  sample_t;
  typedef logic signed [LVL_W_D-1:0] lvl_t;
  typedef logic signed [ACC_W_D-1:0] acc_t;
  typedef logic signed [OUT_W_D-1:0] out_t;

  typedef struct packed {
    logic signed [31:0] val;
    logic               sat;
  } sat_res_t;

  // Works on a 64-bit sign-extended product so any width set up to 64 bits fits.
  function automatic sat_res_t sat_shift(input logic signed [63:0] prod,
                                         input int shift,
                                         input int out_w);
    sat_res_t           res;
    logic signed [63:0] sh;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sh      = prod >>> shift;
    hi      = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo      = -(64'sd1 <<< (out_w - 1));
    res.val = sh[31:0];
    res.sat = 1'b0;
    if (sh > hi) begin
      res.val = hi[31:0];
      res.sat = 1'b1;
    end else if (sh < lo) begin
      res.val = lo[31:0];
      res.sat = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/mm_sat_shift.sv
// Per-destination output scaling: snapshot times destination gain, arithmetic
// shift down, then clamp to the signed output range.
module mm_sat_shift
  import mod_matrix_pkg::*;
#(
  parameter int ACC_W     = ACC_W_D,
  parameter int LVL_W     = LVL_W_D,
  parameter int OUT_W     = OUT_W_D,
  parameter int OUT_SHIFT = OUT_SHIFT_D
) (
  input  logic signed [ACC_W-1:0] i_snap,
  input  logic signed [LVL_W-1:0] i_gain,
  output logic signed [OUT_W-1:0] o_res,
  output logic                    o_sat
);

  localparam int PW = ACC_W + LVL_W;

  logic signed [PW-1:0] w_prod;
  logic signed [63:0]   w_prod64;
  sat_res_t             w_res;

  assign w_prod   = PW'(i_snap) * PW'(i_gain);
  assign w_prod64 = 64'(w_prod);
  assign w_res    = sat_shift(w_prod64, OUT_SHIFT, OUT_W);
  assign o_res    = OUT_W'(w_res.val);
  assign o_sat    = w_res.sat;

endmodule

// File: rtl/mod_matrix_mac.sv
// Modulation-matrix MAC: per voice, sums sample*level*coef into every destination,
// then scales, saturates and stores one result row per voice for random read-back.
module mod_matrix_mac
  import mod_matrix_pkg::*;
#(
  parameter int VOICES    = VOICES_D,
  parameter int V_OSC     = V_OSC_D,
  parameter int V_WIDTH   = V_WIDTH_D,
  parameter int O_WIDTH   = O_WIDTH_D,
  parameter int IN_W      = IN_W_D,
  parameter int LVL_W     = LVL_W_D,
  parameter int ACC_W     = ACC_W_D,
  parameter int OUT_W     = OUT_W_D,
  parameter int OUT_SHIFT = OUT_SHIFT_D
) (
  input  logic                     sCLK_XVXENVS,
  input  logic                     reset_reg_N,
  input  logic                     src_valid,
  input  logic                     src_last,
  input  logic [V_WIDTH-1:0]       src_voice,
  input  logic [O_WIDTH-1:0]       src_osc,
  input  logic [IN_W-1:0]          src_sample,
  input  logic [LVL_W-1:0]         src_level,
  input  logic                     bank_sel,
  input  logic                     coef_we,
  input  logic                     coef_bank,
  input  logic [O_WIDTH-1:0]       coef_dst,
  input  logic [O_WIDTH-1:0]       coef_src,
  input  logic [LVL_W-1:0]         coef_data,
  input  logic [V_OSC*LVL_W-1:0]   dst_gain,
  input  logic [V_WIDTH-1:0]       rd_voice,
  input  logic [O_WIDTH-1:0]       rd_osc,
  input  logic                     sat_clr,
  output logic [OUT_W-1:0]         modulation,
  output logic                     res_valid,
  output logic [V_WIDTH-1:0]       res_voice,
  output logic                     sat_flag,
  output logic                     seq_err
);

  localparam int PROD_W = IN_W + LVL_W;
  localparam int TERM_W = PROD_W + LVL_W;

  logic                      r_s1_vld;
  logic                      r_s1_last;
  logic                      r_s1_bank;
  logic [V_WIDTH-1:0]        r_s1_voice;
  logic [O_WIDTH-1:0]        r_s1_osc;
  logic signed [IN_W-1:0]    r_s1_sample;
  logic signed [LVL_W-1:0]   r_s1_level;

  logic                      r_open;
  logic                      r_bank;
  logic [V_WIDTH-1:0]        r_open_voice;
  logic                      r_seq_err;

  logic                      r_s2_vld;
  logic                      r_s2_last;
  logic                      r_s2_bank;
  logic [V_WIDTH-1:0]        r_s2_voice;
  logic [O_WIDTH-1:0]        r_s2_osc;
  logic signed [PROD_W-1:0]  r_s2_prod;

  logic signed [LVL_W-1:0]   r_coef [2][V_OSC][V_OSC];
  logic signed [ACC_W-1:0]   r_acc  [V_OSC];
  logic signed [ACC_W-1:0]   r_snap [V_OSC];
  logic                      r_s3_vld;
  logic [V_WIDTH-1:0]        r_s3_voice;

  logic signed [OUT_W-1:0]   r_result [VOICES][V_OSC];
  logic [OUT_W-1:0]          r_mod;
  logic                      r_res_valid;
  logic [V_WIDTH-1:0]        r_res_voice;
  logic                      r_sat;

  logic signed [TERM_W-1:0]  w_term [V_OSC];
  logic signed [ACC_W-1:0]   w_sum  [V_OSC];
  logic signed [OUT_W-1:0]   w_r    [V_OSC];
  logic [V_OSC-1:0]          w_sat;

  // Stage 1: capture the sample; the bank is taken from bank_sel only when a voice opens.
  always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin : p_accept
    if (!reset_reg_N) begin
      r_s1_vld     <= 1'b0;
      r_s1_last    <= 1'b0;
      r_s1_bank    <= 1'b0;
      r_s1_voice   <= '0;
      r_s1_osc     <= '0;
      r_s1_sample  <= '0;
      r_s1_level   <= '0;
      r_open       <= 1'b0;
      r_bank       <= 1'b0;
      r_open_voice <= '0;
      r_seq_err    <= 1'b0;
    end else begin
      r_s1_vld <= src_valid;
      if (src_valid) begin
        r_s1_last   <= src_last;
        r_s1_voice  <= src_voice;
        r_s1_osc    <= src_osc;
        r_s1_sample <= src_sample;
        r_s1_level  <= src_level;
        r_open      <= ~src_last;
        if (r_open) begin
          r_s1_bank <= r_bank;
          if (src_voice != r_open_voice) r_seq_err <= 1'b1;
        end else begin
          r_s1_bank    <= bank_sel;
          r_bank       <= bank_sel;
          r_open_voice <= src_voice;
        end
      end
    end
  end

  always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin : p_stage2
    if (!reset_reg_N) begin
      r_s2_vld   <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_bank  <= 1'b0;
      r_s2_voice <= '0;
      r_s2_osc   <= '0;
      r_s2_prod  <= '0;
    end else begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_last  <= r_s1_last;
        r_s2_bank  <= r_s1_bank;
        r_s2_voice <= r_s1_voice;
        r_s2_osc   <= r_s1_osc;
        r_s2_prod  <= PROD_W'(r_s1_sample) * PROD_W'(r_s1_level);
      end
    end
  end

  always_comb begin
    for (int d = 0; d < V_OSC; d++) begin
      w_term[d] = TERM_W'(r_s2_prod) * TERM_W'(r_coef[r_s2_bank][d][r_s2_osc]);
      w_sum[d]  = r_acc[d] + ACC_W'(w_term[d]);
    end
  end

  // Stage 3: a last sample folds into the snapshot and leaves the accumulator at zero,
  // so a sample arriving right behind it starts cleanly.
  always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin : p_stage3
    if (!reset_reg_N) begin
      for (int d = 0; d < V_OSC; d++) begin
        r_acc[d]  <= '0;
        r_snap[d] <= '0;
      end
      r_s3_vld   <= 1'b0;
      r_s3_voice <= '0;
    end else begin
      r_s3_vld <= r_s2_vld & r_s2_last;
      if (r_s2_vld) begin
        for (int d = 0; d < V_OSC; d++) begin
          if (r_s2_last) begin
            r_snap[d] <= w_sum[d];
            r_acc[d]  <= '0;
          end else begin
            r_acc[d] <= w_sum[d];
          end
        end
        r_s3_voice <= r_s2_voice;
      end
    end
  end

  always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin : p_coef
    if (!reset_reg_N) begin
      for (int b = 0; b < 2; b++)
        for (int d = 0; d < V_OSC; d++)
          for (int s = 0; s < V_OSC; s++)
            r_coef[b][d][s] <= '0;
    end else if (coef_we) begin
      r_coef[coef_bank][coef_dst][coef_src] <= coef_data;
    end
  end

  for (genvar gd = 0; gd < V_OSC; gd++) begin : g_dst
    mm_sat_shift #(
      .ACC_W     (ACC_W),
      .LVL_W     (LVL_W),
      .OUT_W     (OUT_W),
      .OUT_SHIFT (OUT_SHIFT)
    ) u_sat (
      .i_snap (r_snap[gd]),
      .i_gain (dst_gain[gd*LVL_W +: LVL_W]),
      .o_res  (w_r[gd]),
      .o_sat  (w_sat[gd])
    );
  end

  // Stage 4: a clamp outranks sat_clr in the same cycle so no saturation event is lost.
  always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin : p_stage4
    if (!reset_reg_N) begin
      for (int v = 0; v < VOICES; v++)
        for (int d = 0; d < V_OSC; d++)
          r_result[v][d] <= '0;
      r_res_valid <= 1'b0;
      r_res_voice <= '0;
      r_sat       <= 1'b0;
    end else begin
      r_res_valid <= r_s3_vld;
      if (r_s3_vld) begin
        for (int d = 0; d < V_OSC; d++)
          r_result[r_s3_voice][d] <= w_r[d];
        r_res_voice <= r_s3_voice;
      end
      if (r_s3_vld && (|w_sat)) r_sat <= 1'b1;
      else if (sat_clr)         r_sat <= 1'b0;
    end
  end

  always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin : p_read
    if (!reset_reg_N) r_mod <= '0;
    else              r_mod <= r_result[rd_voice][rd_osc];
  end

  assign modulation = r_mod;
  assign res_valid  = r_res_valid;
  assign res_voice  = r_res_voice;
  assign sat_flag   = r_sat;
  assign seq_err    = r_seq_err;

endmodule

// File: tb/tb_mod_matrix_mac.sv
// Directed bench for mod_matrix_mac: single-source vector table plus hand-written
// multi-cycle sequences (saturation, back-to-back voices, coef hazards, seq error, reset).
module tb_mod_matrix_mac;

  logic              clk;
  logic              rst_n;
  logic              src_valid, src_last;
  logic [2:0]        src_voice;
  logic [1:0]        src_osc;
  logic [16:0]       src_sample;
  logic [7:0]        src_level;
  logic              bank_sel, coef_we, coef_bank;
  logic [1:0]        coef_dst, coef_src;
  logic [7:0]        coef_data;
  logic [31:0]       dst_gain;
  logic [2:0]        rd_voice;
  logic [1:0]        rd_osc;
  logic              sat_clr;
  logic signed [10:0] modulation;
  logic              res_valid;
  logic [2:0]        res_voice;
  logic              sat_flag, seq_err;

  int n_pass  = 0;
  int n_total = 0;

  mod_matrix_mac dut (
    .sCLK_XVXENVS (clk),
    .reset_reg_N  (rst_n),
    .src_valid    (src_valid),
    .src_last     (src_last),
    .src_voice    (src_voice),
    .src_osc      (src_osc),
    .src_sample   (src_sample),
    .src_level    (src_level),
    .bank_sel     (bank_sel),
    .coef_we      (coef_we),
    .coef_bank    (coef_bank),
    .coef_dst     (coef_dst),
    .coef_src     (coef_src),
    .coef_data    (coef_data),
    .dst_gain     (dst_gain),
    .rd_voice     (rd_voice),
    .rd_osc       (rd_osc),
    .sat_clr      (sat_clr),
    .modulation   (modulation),
    .res_valid    (res_valid),
    .res_voice    (res_voice),
    .sat_flag     (sat_flag),
    .seq_err      (seq_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  typedef struct {
    int voice;
    int osc;
    int dst;
    int sample;
    int level;
    int coef;
    int gain;
    int exp_res;
    int exp_sat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_coef(input int b, input int d, input int s, input int c);
    coef_we   = 1'b1;
    coef_bank = b[0];
    coef_dst  = 2'(d);
    coef_src  = 2'(s);
    coef_data = 8'(c);
    tick();
    coef_we   = 1'b0;
  endtask

  task automatic gain_all(input int g);
    for (int d = 0; d < 4; d++) dst_gain[d*8 +: 8] = 8'(g);
  endtask

  task automatic send(input int v, input int o, input int smp, input int lvl,
                      input int last, input int bank);
    src_valid  = 1'b1;
    src_voice  = 3'(v);
    src_osc    = 2'(o);
    src_sample = 17'(smp);
    src_level  = 8'(lvl);
    src_last   = last[0];
    bank_sel   = bank[0];
    tick();
    src_valid  = 1'b0;
    src_last   = 1'b0;
    bank_sel   = 1'b0;
  endtask

  task automatic wait_res(output int lat);
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (res_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic rd(input int v, input int o, output longint val);
    rd_voice = 3'(v);
    rd_osc   = 2'(o);
    tick();
    val = modulation;
  endtask

  initial begin
    int     lat;
    longint val;
    logic   seen;

    rst_n = 1'b0; src_valid = 0; src_last = 0; src_voice = 0; src_osc = 0;
    src_sample = 0; src_level = 0; bank_sel = 0; coef_we = 0; coef_bank = 0;
    coef_dst = 0; coef_src = 0; coef_data = 0; dst_gain = 0; rd_voice = 0;
    rd_osc = 0; sat_clr = 0;

    //            voice osc dst sample  level coef gain  result sat
    vecs[0] = '{0, 0, 1,  16384,  127,  127, 127,  500,  0};
    vecs[1] = '{1, 2, 3, -16384,  127,  127, 127, -501,  0};
    vecs[2] = '{7, 3, 0,  65535,  127,  127, 127,  1023, 1};
    vecs[3] = '{3, 1, 2, -65536,  127,  127, 127, -1024, 1};
    vecs[4] = '{5, 0, 0,     -1,    1,    1,   1,   -1,  0};
    vecs[5] = '{2, 1, 1,    100, -128, -128, 100,    2,  0};
    vecs[6] = '{6, 3, 2,  65535,  127,  127,   0,    0,  0};
    vecs[7] = '{4, 2, 3,   1000,   64,   64,  64,    3,  0};

    #2;
    chk("rst_modulation", modulation, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_sat_flag", sat_flag, 0);
    chk("rst_seq_err", seq_err, 0);
    #20 rst_n = 1'b1;
    rd(0, 0, val);
    chk("rst_result_0_0", val, 0);

    for (int i = 0; i < 8; i++) begin
      gain_all(vecs[i].gain);
      wr_coef(0, vecs[i].dst, vecs[i].osc, vecs[i].coef);
      sat_clr = 1'b1;
      tick();
      sat_clr = 1'b0;
      send(vecs[i].voice, vecs[i].osc, vecs[i].sample, vecs[i].level, 1, 0);
      wait_res(lat);
      chk($sformatf("vec%0d_latency", i), lat, 3);
      chk($sformatf("vec%0d_res_voice", i), res_voice, vecs[i].voice);
      tick();
      chk($sformatf("vec%0d_pulse_width", i), res_valid, 0);
      rd(vecs[i].voice, vecs[i].dst, val);
      chk($sformatf("vec%0d_result", i), val, vecs[i].exp_res);
      chk($sformatf("vec%0d_sat_flag", i), sat_flag, vecs[i].exp_sat);
      if (i == 0) begin
        for (int d = 0; d < 4; d++) begin
          if (d != vecs[i].dst) begin
            rd(vecs[i].voice, d, val);
            chk($sformatf("vec0_other_dst%0d", d), val, 0);
          end
        end
      end
      wr_coef(0, vecs[i].dst, vecs[i].osc, 0);
    end

    // Four full-scale sources into every destination
    gain_all(127);
    for (int d = 0; d < 4; d++)
      for (int s = 0; s < 4; s++)
        wr_coef(0, d, s, 127);
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    for (int s = 0; s < 4; s++) send(1, s, 65535, 127, (s == 3) ? 1 : 0, 0);
    wait_res(lat);
    chk("pos4_latency", lat, 3);
    for (int d = 0; d < 4; d++) begin
      rd(1, d, val);
      chk($sformatf("pos4_result_d%0d", d), val, 1023);
    end
    chk("pos4_sat_flag", sat_flag, 1);
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    chk("sat_clr_clears", sat_flag, 0);

    // Negative run with sat_clr held high and a read parked on the entry being written
    rd_voice = 3'd1;
    rd_osc   = 2'd0;
    sat_clr  = 1'b1;
    for (int s = 0; s < 4; s++) send(1, s, -65536, 127, (s == 3) ? 1 : 0, 0);
    wait_res(lat);
    chk("neg4_latency", lat, 3);
    chk("neg4_sat_vs_clr", sat_flag, 1);
    chk("neg4_read_old", modulation, 1023);
    sat_clr = 1'b0;
    tick();
    chk("neg4_read_new", modulation, -1024);
    for (int d = 1; d < 4; d++) begin
      rd(1, d, val);
      chk($sformatf("neg4_result_d%0d", d), val, -1024);
    end

    // Back-to-back voices using different banks
    for (int d = 0; d < 4; d++) wr_coef(1, d, 0, -127);
    send(2, 0, 16384, 127, 1, 0);
    send(3, 0, 16384, 127, 1, 1);
    wait_res(lat);
    chk("b2b_latency", lat, 2);
    chk("b2b_first_voice", res_voice, 2);
    tick();
    chk("b2b_second_pulse", res_valid, 1);
    chk("b2b_second_voice", res_voice, 3);
    tick();
    chk("b2b_pulse_end", res_valid, 0);
    rd(2, 1, val);
    chk("b2b_v2_bank0", val, 500);
    rd(3, 2, val);
    chk("b2b_v3_bank1", val, -501);

    // Coefficient rewritten on the very edge that stage 3 reads it
    send(0, 0, 16384, 127, 1, 0);
    tick();
    wr_coef(0, 0, 0, 64);
    wait_res(lat);
    chk("coefhaz_latency", lat, 1);
    rd(0, 0, val);
    chk("coefhaz_old_value", val, 500);
    send(0, 0, 16384, 127, 1, 0);
    wait_res(lat);
    chk("coefhaz_next_latency", lat, 3);
    rd(0, 0, val);
    chk("coefhaz_new_value", val, 252);

    // Voice switches without src_last
    chk("seqerr_before", seq_err, 0);
    send(4, 0, 16384, 127, 0, 0);
    chk("seqerr_first", seq_err, 0);
    send(5, 1, 16384, 127, 1, 0);
    chk("seqerr_set", seq_err, 1);
    wait_res(lat);
    chk("seqerr_latency", lat, 3);
    chk("seqerr_res_voice", res_voice, 5);
    rd(5, 0, val);
    chk("seqerr_acc_d0", val, 752);
    rd(5, 1, val);
    chk("seqerr_acc_d1", val, 1000);

    // Reset pulse in the middle of voice 6
    send(6, 0, 16384, 127, 0, 0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_modulation", modulation, 0);
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_res_voice", res_voice, 0);
    chk("midrst_sat_flag", sat_flag, 0);
    chk("midrst_seq_err", seq_err, 0);
    #2 rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (res_valid) seen = 1'b1;
    end
    chk("midrst_no_res_valid", seen, 0);
    rd(5, 0, val);
    chk("midrst_results_cleared", val, 0);
    wr_coef(0, 0, 0, 127);
    send(6, 0, 16384, 127, 1, 0);
    wait_res(lat);
    chk("postrst_latency", lat, 3);
    rd(6, 0, val);
    chk("postrst_v6_d0", val, 500);
    rd(6, 1, val);
    chk("postrst_v6_d1", val, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mod_matrix_mac.md
MOD_MATRIX_MAC -- requirements
Module: mod_matrix_mac

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- VOICES, 8, voices per frame.
- V_OSC, 4, oscillators per voice; each is both a source and a destination.
- V_WIDTH, 3, voice index width.
- O_WIDTH, 2, osc index width.
- IN_W, 17, signed source sample width.
- LVL_W, 8, signed level and coefficient width.
- ACC_W, 40, signed accumulator width.
- OUT_W, 11, signed modulation output width.
- OUT_SHIFT, 26, arithmetic right shift applied before saturation.
REQ-002 Ports, one per line: name, direction, width, meaning.
- sCLK_XVXENVS, in, 1, sole clock.
- reset_reg_N, in, 1, asynchronous active-low reset.
- src_valid, in, 1, source sample present.
- src_last, in, 1, last source of the current voice.
- src_voice, in, V_WIDTH, voice of the sample.
- src_osc, in, O_WIDTH, source osc.
- src_sample, in, IN_W, sine sample.
- src_level, in, LVL_W, envelope×velocity level.
- bank_sel, in, 1, coefficient bank for the next voice.
- coef_we, in, 1, coefficient write strobe.
- coef_bank, in, 1, write bank.
- coef_dst, in, O_WIDTH, write row.
- coef_src, in, O_WIDTH, write column.
- coef_data, in, LVL_W, write value.
- dst_gain, in, V_OSC×LVL_W, per-destination input gain.
- rd_voice, in, V_WIDTH, read voice address.
- rd_osc, in, O_WIDTH, read osc address.
- sat_clr, in, 1, clear the sticky saturation flag.
- modulation, out, OUT_W, registered read data.
- res_valid, out, 1, one-cycle pulse when a voice result is written.
- res_voice, out, V_WIDTH, voice just written.
- sat_flag, out, 1, sticky saturation flag.
- seq_err, out, 1, sticky sequence-error flag.

Function
REQ-003 Stage 1 (accept cycle t) SHALL register the sample, level, osc, voice and last fields when src_valid=1.
REQ-004 Stage 2 (t+1) SHALL form p = sample×level, a full-precision 25-bit signed value.
REQ-005 Stage 3 (t+2) SHALL, for every destination d in parallel, add p×coef[bank][d][osc] to acc[d], sign-extended to ACC_W, with no wrap checking.
REQ-006 The bank used for a voice SHALL be latched from bank_sel at that voice's first accepted sample and held until its src_last.
REQ-007 At stage 3 of a src_last sample, the block SHALL:
- set snap[d] = acc[d] + that sample's product;
- clear acc[d] to 0.
REQ-008 A sample accepted at t+1, immediately after a src_last, SHALL start a fresh accumulation with acc[d] = its product, with no loss and no stall.
REQ-009 At t+3, the block SHALL compute r[d] = sat_OUT_W((snap[d]×dst_gain[d]) >>> OUT_SHIFT).
- Write r[d] to result[voice][d] for every d.
- Pulse res_valid for one cycle with res_voice; res_valid and the write SHALL share the same edge.
REQ-010 Saturation SHALL clamp to +2^(OUT_W-1)-1 or -2^(OUT_W-1), and any clamp SHALL set sat_flag.
REQ-011 sat_flag SHALL clear on sat_clr; if a clamp occurs in the same cycle as sat_clr, the flag SHALL remain set.
REQ-012 modulation SHALL equal result[rd_voice][rd_osc] one cycle after the address is presented.
- A read of an entry being written that same cycle SHALL return the old value.
REQ-013 A coef_we write SHALL take effect from the next cycle.
- A stage-3 use of the same entry in the write cycle SHALL see the old value.
REQ-014 seq_err SHALL set when a valid sample's src_voice differs from the open voice before that voice's src_last has been accepted.
- Accumulation SHALL continue unchanged.
- seq_err SHALL clear only on reset.
REQ-015 src_valid=0 cycles SHALL leave all state unchanged; gaps inside a voice are legal.

Reset
REQ-016 Assertion of reset_reg_N SHALL asynchronously clear:
- pipeline valids, accumulators, snapshots, results and coefficients to 0;
- modulation, res_valid, res_voice, sat_flag and seq_err to 0;
- the latched bank to 0.
REQ-017 A reset mid-voice SHALL discard the partial sum, with no res_valid for that voice after release.
REQ-018 Release SHALL be synchronised to sCLK_XVXENVS by the parent; the first accept is legal on the cycle after release.

Structure
REQ-019 Package mod_matrix_pkg SHALL hold:
- the default widths;
- typedefs sample_t, lvl_t, acc_t, out_t;
- function sat_shift.
REQ-020 Sub-module mm_sat_shift SHALL implement the REQ-009/REQ-010 gain, shift and saturation, with one instance per destination.

Verification
REQ-021 Reset to voice 0, osc 0: coef[0][1][0]=127, gain[1]=127, sample=16384, level=127, src_last -> res_valid at t+3; result[0][1]=500; other entries 0.
REQ-022 Four sources at 65535, level 127, all coef/gain 127 -> result=1023 and sat_flag=1; the same test at -65536 -> result=-1024.
REQ-023 Voices 2 and 3 back-to-back with no gap, bank 0 for v2 and bank 1 for v3 (differing coefs) -> two res_valid pulses one cycle apart, each using the correct bank.
REQ-024 coef_we to entry [0][0][0] in the same cycle that entry is used -> old value is used; the next voice uses the new value.
REQ-025 Voice 4 src_voice switches to 5 without src_last -> seq_err=1, and accumulation continues.
REQ-026 reset_reg_N pulsed between two samples of voice 6 -> no res_valid; all outputs 0; post-reset voice 6 result excludes pre-reset samples.
